ltc_counter: RTL and testbench



---
 rtl/ltc_counter.sv | 89 ++++++++
 tb/tb_ltc_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ltc_counter.sv
// 48-bit local time counter with read-snapshot / write-load task handshake
// for the register block's LTC task register.
module ltc_counter #(
  parameter int unsigned  P_INC       = 1,
  parameter logic [47:0]  P_RESET_VAL = 48'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ltc_en,
  input  logic        ltc_rd_req,
  output logic        ltc_rd_ack,
  output logic [47:0] ltc_rd_data,
  input  logic        ltc_wr_req,
  output logic        ltc_wr_ack,
  input  logic [47:0] ltc_wr_data,
  output logic [47:0] ltc_count,
  output logic        ltc_wrap
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

  localparam logic [48:0] INC49 = 49'(P_INC);

  state_t      state, state_nxt;
  logic [48:0] sum;
  logic [47:0] count_nxt;
  logic [47:0] rd_data_nxt;
  logic        rd_ack_nxt;
  logic        wr_ack_nxt;
  logic        wrap_nxt;

  assign sum = {1'b0, ltc_count} + INC49;

  always_comb begin
    state_nxt   = state;
    rd_ack_nxt  = 1'b0;
    wr_ack_nxt  = 1'b0;
    rd_data_nxt = ltc_rd_data;
    count_nxt   = ltc_en ? sum[47:0] : ltc_count;
    wrap_nxt    = ltc_en & sum[48];

    unique case (state)
      IDLE: begin
        if (ltc_rd_req) begin
          // Snapshot is the pre-increment value; the counter keeps running.
          rd_data_nxt = ltc_count;
          rd_ack_nxt  = 1'b1;
          state_nxt   = RD_WAIT;
        end else if (ltc_wr_req) begin
          // Load wins over the increment, so no wrap can be flagged here.
          count_nxt  = ltc_wr_data;
          wrap_nxt   = 1'b0;
          wr_ack_nxt = 1'b1;
          state_nxt  = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (!ltc_rd_req) state_nxt = IDLE;
      end
      WR_WAIT: begin
        if (!ltc_wr_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ltc_count   <= P_RESET_VAL;
      ltc_rd_data <= '0;
      ltc_rd_ack  <= 1'b0;
      ltc_wr_ack  <= 1'b0;
      ltc_wrap    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ltc_count   <= count_nxt;
      ltc_rd_data <= rd_data_nxt;
      ltc_rd_ack  <= rd_ack_nxt;
      ltc_wr_ack  <= wr_ack_nxt;
      ltc_wrap    <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_ltc_counter.sv
// Bench for ltc_counter: directed handshakes, expected acks queued and
// checked by an independent monitor on the falling edge.
module tb_ltc_counter;

  localparam logic [47:0] INC = 48'd1;
  localparam logic [47:0] RST = 48'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ltc_en;
  logic        ltc_rd_req;
  logic        ltc_rd_ack;
  logic [47:0] ltc_rd_data;
  logic        ltc_wr_req;
  logic        ltc_wr_ack;
  logic [47:0] ltc_wr_data;
  logic [47:0] ltc_count;
  logic        ltc_wrap;

  ltc_counter #(
    .P_INC       (1),
    .P_RESET_VAL (48'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ltc_en      (ltc_en),
    .ltc_rd_req  (ltc_rd_req),
    .ltc_rd_ack  (ltc_rd_ack),
    .ltc_rd_data (ltc_rd_data),
    .ltc_wr_req  (ltc_wr_req),
    .ltc_wr_ack  (ltc_wr_ack),
    .ltc_wr_data (ltc_wr_data),
    .ltc_count   (ltc_count),
    .ltc_wrap    (ltc_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [47:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned rd_seen = 0;
  int unsigned wr_seen = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every ack pops one expectation, in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ltc_rd_ack === 1'b1) begin
        rd_seen++;
        if (sb.size() == 0) check("rd_ack_unexpected", 48'd1, 48'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_ack_order", {47'd0, e.is_wr}, 48'd0);
          check("rd_data", ltc_rd_data, e.val);
        end
      end
      if (ltc_wr_ack === 1'b1) begin
        wr_seen++;
        if (sb.size() == 0) check("wr_ack_unexpected", 48'd1, 48'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("wr_ack_order", {47'd0, e.is_wr}, 48'd1);
          check("wr_load_count", ltc_count, e.val);
          check("wr_cycle_wrap", {47'd0, ltc_wrap}, 48'd0);
        end
      end
    end
  end

  // Full write handshake; returns one cycle after the request drops (FSM in IDLE).
  task automatic do_write(input logic [47:0] val);
    bit got;
    got = 1'b0;
    sb.push_back('{is_wr: 1'b1, val: val});
    ltc_wr_data = val;
    ltc_wr_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ltc_wr_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("wr_ack_timeout", 48'd0, 48'd1);
    ltc_wr_req = 1'b0;
    tick(1);
  endtask

  initial begin
    int unsigned rd0;
    rst_n       = 1'b0;
    ltc_en      = 1'b0;
    ltc_rd_req  = 1'b0;
    ltc_wr_req  = 1'b0;
    ltc_wr_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", ltc_count, RST);
    check("rst_rd_data", ltc_rd_data, 48'd0);
    check("rst_flags", {45'd0, ltc_rd_ack, ltc_wr_ack, ltc_wrap}, 48'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Free-run 10 cycles, then hold
    ltc_en = 1'b1;
    tick(10);
    ltc_en = 1'b0;
    check("run10_count", ltc_count, RST + 48'd10);
    tick(3);
    check("hold_count", ltc_count, RST + 48'd10);

    // Read snapshot while counting, request held 5 cycles
    do_write(48'h1234);
    check("load_1234", ltc_count, 48'h1234);
    rd0 = rd_seen;
    sb.push_back('{is_wr: 1'b0, val: 48'h1234});
    ltc_en     = 1'b1;
    ltc_rd_req = 1'b1;
    tick(5);
    ltc_rd_req = 1'b0;
    ltc_en     = 1'b0;
    check("rd_hold_count", ltc_count, 48'h1234 + 48'd5);
    check("rd_hold_data", ltc_rd_data, 48'h1234);
    check("rd_single_ack", 48'(rd_seen - rd0), 48'd1);
    tick(1);
    check("rd_after_idle", ltc_count, 48'h1234 + 48'd5);

    // Write with counting enabled: load then first increment next edge
    ltc_en = 1'b1;
    do_write(48'h0000_DEAD_BEEF);
    ltc_en = 1'b0;
    check("wr_then_inc", ltc_count, 48'h0000_DEAD_BEEF + INC);

    // Load overrides a would-be wrap, then wrap FFFE -> FFFF -> 0
    do_write(48'hFFFF_FFFF_FFFF);
    ltc_en = 1'b1;
    do_write(48'hFFFF_FFFF_FFFE);
    check("pre_wrap_count", ltc_count, 48'hFFFF_FFFF_FFFF);
    check("pre_wrap_flag", {47'd0, ltc_wrap}, 48'd0);
    tick(1);
    check("wrap_count", ltc_count, 48'h0);
    check("wrap_flag", {47'd0, ltc_wrap}, 48'd1);
    tick(1);
    ltc_en = 1'b0;
    check("post_wrap_count", ltc_count, 48'h1);
    check("post_wrap_flag", {47'd0, ltc_wrap}, 48'd0);

    // Simultaneous read and write: read first, write two cycles later
    do_write(48'h0123_4567_89AB);
    sb.push_back('{is_wr: 1'b0, val: 48'h0123_4567_89AB});
    sb.push_back('{is_wr: 1'b1, val: 48'hA5A5_0000_0001});
    ltc_en      = 1'b1;
    ltc_wr_data = 48'hA5A5_0000_0001;
    ltc_rd_req  = 1'b1;
    ltc_wr_req  = 1'b1;
    tick(1);
    check("both_rd_ack", {46'd0, ltc_rd_ack, ltc_wr_ack}, 48'b10);
    ltc_rd_req = 1'b0;
    tick(1);
    check("both_gap", {46'd0, ltc_rd_ack, ltc_wr_ack}, 48'b00);
    tick(1);
    check("both_wr_ack", {46'd0, ltc_rd_ack, ltc_wr_ack}, 48'b01);
    check("both_rd_data_kept", ltc_rd_data, 48'h0123_4567_89AB);
    ltc_wr_req = 1'b0;
    tick(1);
    ltc_en = 1'b0;
    check("both_count", ltc_count, 48'hA5A5_0000_0002);

    // Reset in RD_WAIT with request held high
    sb.push_back('{is_wr: 1'b0, val: 48'hA5A5_0000_0002});
    ltc_rd_req = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", ltc_count, RST);
    check("async_rst_data", ltc_rd_data, 48'd0);
    check("async_rst_flags", {45'd0, ltc_rd_ack, ltc_wr_ack, ltc_wrap}, 48'd0);
    tick(1);
    rd0 = rd_seen;
    sb.push_back('{is_wr: 1'b0, val: RST});
    rst_n  = 1'b1;
    ltc_en = 1'b1;
    tick(1);
    check("rerd_ack", {47'd0, ltc_rd_ack}, 48'd1);
    check("rerd_count", ltc_count, RST + INC);
    ltc_rd_req = 1'b0;
    ltc_en     = 1'b0;
    tick(2);
    check("rerd_single_ack", 48'(rd_seen - rd0), 48'd1);
    check("sb_drained", 48'(sb.size()), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
